// File: rtl/sha_logic_if.sv
// sha_logic_if: operand/result handshake bundle for sha_logic_unit
interface sha_logic_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       mode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;
  logic [CNT_W-1:0] op_count;
  modport master (
    output in_valid, mode, x, y, z, out_ready,
    input  in_ready, out_valid, result, err, op_count
  );
  modport slave (
    input  in_valid, mode, x, y, z, out_ready,
    output in_ready, out_valid, result, err, op_count
  );
endinterface

// File: rtl/sha_logic_unit.sv
// sha_logic_unit: two-stage SHA-2 logic functions (Ch/Maj/Parity/Sigmas); Sigma modes need SHA_LOGIC_SIGMA_EN
module sha_logic_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic       clk,
  input logic       rst,
  sha_logic_if.slave bus
);
`ifdef SHA_LOGIC_SIGMA_EN
  localparam int B0A = WIDTH == 64 ? 28 : 2;
  localparam int B0B = WIDTH == 64 ? 34 : 13;
  localparam int B0C = WIDTH == 64 ? 39 : 22;
  localparam int B1A = WIDTH == 64 ? 14 : 6;
  localparam int B1B = WIDTH == 64 ? 18 : 11;
  localparam int B1C = WIDTH == 64 ? 41 : 25;
  localparam int S0A = WIDTH == 64 ? 1 : 7;
  localparam int S0B = WIDTH == 64 ? 8 : 18;
  localparam int S0C = WIDTH == 64 ? 7 : 3;
  localparam int S1A = WIDTH == 64 ? 19 : 17;
  localparam int S1B = WIDTH == 64 ? 61 : 19;
  localparam int S1C = WIDTH == 64 ? 6 : 10;
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
    return (v >> n) | (v << (WIDTH - n));
  endfunction
`endif
  logic             s1_v;
  logic             s2_v;
  logic [2:0]       s1_mode;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic [WIDTH-1:0] s1_z;
  logic [WIDTH-1:0] f;
  logic             e;
  logic             adv;
  // both stages move whenever the output slot is free or being drained
  assign adv           = !s2_v || bus.out_ready;
  assign bus.in_ready  = rst && (!s1_v || adv);
  assign bus.out_valid = s2_v;
  // function select on stage-1 contents; unknown or compiled-out modes flag err with a zero result
  always_comb begin
    f = '0;
    e = 1'b0;
    case (s1_mode)
      3'd0: f = (s1_x & s1_y) | (~s1_x & s1_z);
      3'd1: f = (s1_x & s1_y) | (s1_x & s1_z) | (s1_y & s1_z);
      3'd2: f = s1_x ^ s1_y ^ s1_z;
`ifdef SHA_LOGIC_SIGMA_EN
      3'd3: f = rotr(s1_x, B0A) ^ rotr(s1_x, B0B) ^ rotr(s1_x, B0C);
      3'd4: f = rotr(s1_x, B1A) ^ rotr(s1_x, B1B) ^ rotr(s1_x, B1C);
      3'd5: f = rotr(s1_x, S0A) ^ rotr(s1_x, S0B) ^ (s1_x >> S0C);
      3'd6: f = rotr(s1_x, S1A) ^ rotr(s1_x, S1B) ^ (s1_x >> S1C);
`endif
      default: e = 1'b1;
    endcase
  end
  // pipeline registers and completed-transfer counter; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      bus.result   <= '0;
      bus.err      <= 1'b0;
      bus.op_count <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_v    <= bus.in_valid;
        s1_mode <= bus.mode;
        s1_x    <= bus.x;
        s1_y    <= bus.y;
        s1_z    <= bus.z;
      end
      if (adv) begin
        s2_v       <= s1_v;
        bus.result <= f;
        bus.err    <= e;
      end
      if (s2_v && bus.out_ready) bus.op_count <= bus.op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_sha_logic_unit.sv
// tb_sha_logic_unit: directed-vector bench with an in-order expected-result queue
module tb_sha_logic_unit;
  typedef struct {
    logic [31:0] r;
    logic        e;
  } exp_t;
  logic        clk;
  logic        rst;
  logic [31:0] cur_r;
  logic        cur_e;
  logic [31:0] held;
  logic [31:0] beats [4];
  exp_t        q [$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_pop = 0;
  int          prev_pop = 0;
  int          idx;
  sha_logic_if #(.WIDTH(32), .CNT_W(4)) bus ();
  sha_logic_unit #(.WIDTH(32), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] er, input logic ee);
    bus.in_valid = 1'b1;
    bus.mode = m;
    bus.x = a;
    bus.y = b;
    bus.z = c;
    cur_r = er;
    cur_e = ee;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        bus.in_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("send_timeout", 1, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) return;
      tick();
    end
    chk("drain_timeout", q.size(), 0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) q.delete();
      else begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            chk("result", bus.result, q[0].r);
            chk("err", bus.err, q[0].e);
            void'(q.pop_front());
          end
          prev_pop = last_pop;
          last_pop = cyc;
        end
        if (bus.in_valid && bus.in_ready) q.push_back('{cur_r, cur_e});
      end
    end
  end
  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode = 3'd0;
    bus.x = '0;
    bus.y = '0;
    bus.z = '0;
    cur_r = '0;
    cur_e = 1'b0;
    beats[0] = 32'h11111111;
    beats[1] = 32'h22222222;
    beats[2] = 32'h33333333;
    beats[3] = 32'h44444444;
    tick();
    tick();
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_op_count", bus.op_count, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_err", bus.err, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    tick();
    idx = 0;
    for (int c = 0; c < 30 && (idx < 4 || q.size() > 0); c++) begin
      bus.out_ready = (c >= 5);
      bus.in_valid = (idx < 4);
      bus.mode = 3'd2;
      bus.x = idx < 4 ? beats[idx] : 32'h0;
      bus.y = '0;
      bus.z = '0;
      cur_r = bus.x;
      cur_e = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_accepted", idx, 2);
        chk("stall_out_valid", bus.out_valid, 1);
        held = bus.result;
      end
      if (c == 4) begin
        chk("stall_hold_result", bus.result, held);
        chk("stall_hold_in_ready", bus.in_ready, 0);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stall_drained", q.size(), 0);
    chk("stall_op_count", bus.op_count, 4);
    bus.out_ready = 1'b0;
    send(3'd2, 32'hAAAA0000, 32'h0, 32'h0, 32'hAAAA0000, 1'b0);
    send(3'd2, 32'h0000BBBB, 32'h0, 32'h0, 32'h0000BBBB, 1'b0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_op_count", bus.op_count, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    tick();
    @(negedge clk);
    chk("flush_out_valid2", bus.out_valid, 0);
    tick();
    send(3'd2, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'h00000000, 32'h55555555, 1'b0);
    drain();
    chk("after_flush_op_count", bus.op_count, 1);
    bus.in_valid = 1'b1;
    bus.mode = 3'd0;
    bus.x = 32'hFFFF0000;
    bus.y = 32'h12345678;
    bus.z = 32'h9ABCDEF0;
    cur_r = 32'h1234DEF0;
    cur_e = 1'b0;
    @(negedge clk);
    chk("lat_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_out_valid", bus.out_valid, 0);
    tick();
    @(negedge clk);
    chk("lat2_out_valid", bus.out_valid, 1);
    tick();
    send(3'd1, 32'hF0F0F0F0, 32'hCCCCCCCC, 32'hAAAAAAAA, 32'hE8E8E8E8, 1'b0);
    send(3'd2, 32'hF0F0F0F0, 32'hCCCCCCCC, 32'hAAAAAAAA, 32'h96969696, 1'b0);
    drain();
    chk("b2b_gap", last_pop - prev_pop, 1);
`ifdef SHA_LOGIC_SIGMA_EN
    send(3'd3, 32'h1, 32'h0, 32'h0, 32'h40080400, 1'b0);
    send(3'd4, 32'h1, 32'h0, 32'h0, 32'h04200080, 1'b0);
    send(3'd5, 32'h1, 32'h0, 32'h0, 32'h02004000, 1'b0);
    send(3'd6, 32'h1, 32'h0, 32'h0, 32'h0000A000, 1'b0);
`else
    send(3'd3, 32'h1, 32'h0, 32'h0, 32'h0, 1'b1);
    send(3'd4, 32'h1, 32'h0, 32'h0, 32'h0, 1'b1);
    send(3'd5, 32'h1, 32'h0, 32'h0, 32'h0, 1'b1);
    send(3'd6, 32'h1, 32'h0, 32'h0, 32'h0, 1'b1);
`endif
    send(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
    send(3'd0, 32'h0F0F0F0F, 32'h11111111, 32'h22222222, 32'h21212121, 1'b0);
    drain();
    do_reset();
    for (int i = 0; i < 15; i++) send(3'd2, i, 32'h0, 32'h0, i, 1'b0);
    drain();
    chk("cnt_15", bus.op_count, 15);
    send(3'd7, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1);
    send(3'd2, 32'h00FF00FF, 32'hFF00FF00, 32'h0, 32'hFFFFFFFF, 1'b0);
    drain();
    chk("cnt_wrap", bus.op_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
